// File: rtl/video_timing_gen.sv
// Raster timing generator for the 6847 replacement: sync, blanking, active window,
// fetch strobes and character-row tracking, all registered and mutually aligned.
module video_timing_gen #(
  parameter int CW           = 9,
  parameter int H_TOTAL      = 228,
  parameter int H_SYNC       = 14,
  parameter int H_ACT_START  = 64,
  parameter int H_ACT_LEN    = 128,
  parameter int PRELOAD      = 2,
  parameter int V_TOTAL_PAL  = 312,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOP_PAL    = 64,
  parameter int V_TOP_NTSC   = 48,
  parameter int V_ACTIVE     = 192,
  parameter int VSYNC_LINES  = 4,
  parameter int ROW_HEIGHT   = 12
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          FrameFormat,
  input  logic          AnG,
  input  logic [2:0]    GMode,
  output logic          PixelEn,
  output logic          HSn,
  output logic          FSn,
  output logic          BackPorch,
  output logic          Active,
  output logic          Load,
  output logic          DA0,
  output logic [3:0]    AlphaRow,
  output logic          FrameStart,
  output logic [CW-1:0] Column,
  output logic [CW-1:0] Line
);

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VL_PAL    = CW'(V_TOTAL_PAL - 1);
  localparam logic [CW-1:0] VL_NTSC   = CW'(V_TOTAL_NTSC - 1);
  localparam logic [CW-1:0] TOP_PAL   = CW'(V_TOP_PAL);
  localparam logic [CW-1:0] TOP_NTSC  = CW'(V_TOP_NTSC);
  localparam logic [CW-1:0] ACT_LINES = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_END    = CW'(H_SYNC);
  localparam logic [CW-1:0] VS_END    = CW'(VSYNC_LINES);
  localparam logic [CW-1:0] ACT_START = CW'(H_ACT_START);
  localparam logic [CW-1:0] ACT_END   = CW'(H_ACT_START + H_ACT_LEN);
  localparam logic [CW-1:0] WIN_START = CW'(H_ACT_START - PRELOAD);
  localparam logic [3:0]    ROW_LAST  = 4'(ROW_HEIGHT - 1);

  // Raster state
  logic [CW-1:0] col_q, col_d, line_q, line_d;
  logic          fmt_q, fmt_d, slow_q, slow_d, phase_q, phase_d;
  logic [3:0]    arow_q, arow_d;

  // Registered outputs
  logic          pixen_q, pixen_d, hsn_q, hsn_d, fsn_q, fsn_d, bp_q, bp_d;
  logic          act_q, act_d, load_q, load_d, da0_q, da0_d, fs_q, fs_d;
  logic [3:0]    alpha_q, alpha_d;
  logic [CW-1:0] column_q, column_d, lineo_q, lineo_d;

  logic          col_wrap, a_row, a_col, pix_en;
  logic [CW-1:0] vt_last, top, top_n;
  logic [2:0]    pix_rel;
  logic [1:0]    win_rel;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    col_wrap = (col_q == H_LAST);
    vt_last  = fmt_q ? VL_PAL : VL_NTSC;
    top      = fmt_q ? TOP_PAL : TOP_NTSC;

    col_d   = col_wrap ? '0 : col_q + 1'b1;
    line_d  = line_q;
    if (col_wrap) line_d = (line_q == vt_last) ? '0 : line_q + 1'b1;
    // Format only changes on the last cycle of a frame, so a frame never changes length.
    fmt_d   = (col_wrap && line_q == vt_last) ? FrameFormat : fmt_q;
    slow_d  = col_wrap ? (AnG && GMode == 3'd0) : slow_q;
    phase_d = col_wrap ? 1'b0 : ~phase_q;

    // Character-row index follows the line that is about to start.
    top_n  = fmt_d ? TOP_PAL : TOP_NTSC;
    arow_d = arow_q;
    if (col_wrap) begin
      if (line_d == top_n)
        arow_d = '0;
      else if (line_d > top_n && line_d < top_n + ACT_LINES)
        arow_d = (arow_q == ROW_LAST) ? 4'd0 : arow_q + 4'd1;
    end

    a_row   = (line_q >= top) && (line_q < top + ACT_LINES);
    a_col   = (col_q >= ACT_START) && (col_q < ACT_END);
    pix_en  = !slow_q || !phase_q;
    pix_rel = col_q[2:0] - ACT_START[2:0];
    win_rel = col_q[1:0] - WIN_START[1:0];

    pixen_d  = pix_en;
    hsn_d    = (col_q >= HS_END);
    fsn_d    = (line_q >= VS_END);
    act_d    = a_row && a_col;
    bp_d     = !a_col || !fsn_d;
    load_d   = act_d && pix_en && ((slow_q ? pix_rel[2:1] : pix_rel[1:0]) == 2'd0);
    da0_d    = a_row && (col_q >= WIN_START) && (win_rel >= 2'd2);
    alpha_d  = arow_q;
    fs_d     = (col_q == '0) && (line_q == '0);
    column_d = col_q;
    lineo_d  = line_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      col_q    <= '0;
      line_q   <= '0;
      fmt_q    <= 1'b1;
      slow_q   <= 1'b0;
      phase_q  <= 1'b0;
      arow_q   <= '0;
      pixen_q  <= 1'b0;
      hsn_q    <= 1'b1;
      fsn_q    <= 1'b1;
      bp_q     <= 1'b1;
      act_q    <= 1'b0;
      load_q   <= 1'b0;
      da0_q    <= 1'b0;
      alpha_q  <= '0;
      fs_q     <= 1'b0;
      column_q <= '0;
      lineo_q  <= '0;
    end else begin
      col_q    <= col_d;
      line_q   <= line_d;
      fmt_q    <= fmt_d;
      slow_q   <= slow_d;
      phase_q  <= phase_d;
      arow_q   <= arow_d;
      pixen_q  <= pixen_d;
      hsn_q    <= hsn_d;
      fsn_q    <= fsn_d;
      bp_q     <= bp_d;
      act_q    <= act_d;
      load_q   <= load_d;
      da0_q    <= da0_d;
      alpha_q  <= alpha_d;
      fs_q     <= fs_d;
      column_q <= column_d;
      lineo_q  <= lineo_d;
    end
  end

  assign PixelEn    = pixen_q;
  assign HSn        = hsn_q;
  assign FSn        = fsn_q;
  assign BackPorch  = bp_q;
  assign Active     = act_q;
  assign Load       = load_q;
  assign DA0        = da0_q;
  assign AlphaRow   = alpha_q;
  assign FrameStart = fs_q;
  assign Column     = column_q;
  assign Line       = lineo_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen; vertical geometry is shrunk so whole frames stay short.
module tb_video_timing_gen;

  localparam int CW      = 9;
  localparam int VT_PAL  = 40;
  localparam int VT_NTSC = 30;
  localparam int TOP_PAL = 10;
  localparam int TOP_NT  = 8;
  localparam int V_ACT   = 24;
  localparam int BUDGET  = 20000;

  logic          Clk, Reset, FrameFormat, AnG;
  logic [2:0]    GMode;
  logic          PixelEn, HSn, FSn, BackPorch, Active, Load, DA0, FrameStart;
  logic [3:0]    AlphaRow;
  logic [CW-1:0] Column, Line;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-line measurements
  int         m_hs, m_act, m_bp, m_ld, m_pe, m_fs;
  int         m_first_act, m_last_act, m_ld1, m_ld2;
  logic       m_pe1;
  logic [7:0] m_da0;

  video_timing_gen #(
    .CW(CW), .H_TOTAL(228), .H_SYNC(14), .H_ACT_START(64), .H_ACT_LEN(128), .PRELOAD(2),
    .V_TOTAL_PAL(VT_PAL), .V_TOTAL_NTSC(VT_NTSC), .V_TOP_PAL(TOP_PAL), .V_TOP_NTSC(TOP_NT),
    .V_ACTIVE(V_ACT), .VSYNC_LINES(4), .ROW_HEIGHT(12)
  ) dut (
    .Clk(Clk), .Reset(Reset), .FrameFormat(FrameFormat), .AnG(AnG), .GMode(GMode),
    .PixelEn(PixelEn), .HSn(HSn), .FSn(FSn), .BackPorch(BackPorch), .Active(Active),
    .Load(Load), .DA0(DA0), .AlphaRow(AlphaRow), .FrameStart(FrameStart),
    .Column(Column), .Line(Line)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // DUT changes on negedge; the bench samples and drives on posedge.
  task automatic step();
    @(posedge Clk);
  endtask

  task automatic wait_pos(input int c, input int l);
    int n = 0;
    while (!(int'(Column) == c && int'(Line) == l) && n <= BUDGET) begin
      step();
      n++;
    end
    check($sformatf("reach_%0d_%0d", c, l), (n <= BUDGET), 1);
  endtask

  task automatic frame_len(output int n, input int switch_line);
    n = 0;
    do begin
      step();
      n++;
      if (int'(Line) == switch_line && int'(Column) == 0) FrameFormat = 1'b0;
    end while (!FrameStart && n <= BUDGET);
  endtask

  // Starts at Column 0 of a line, samples all 228 columns, ends at Column 0 of the next line.
  task automatic measure_line();
    m_hs = 0; m_act = 0; m_bp = 0; m_ld = 0; m_pe = 0; m_fs = 0;
    m_first_act = -1; m_last_act = -1; m_ld1 = -1; m_ld2 = -1;
    m_da0 = '0; m_pe1 = 1'bx;
    for (int i = 0; i < 228; i++) begin
      m_hs  += int'(!HSn);
      m_act += int'(Active);
      m_bp  += int'(BackPorch);
      m_ld  += int'(Load);
      m_pe  += int'(PixelEn);
      m_fs  += int'(FrameStart);
      if (Active && m_first_act < 0) m_first_act = int'(Column);
      if (Active) m_last_act = int'(Column);
      if (Load) begin
        if (m_ld1 < 0) m_ld1 = int'(Column);
        else if (m_ld2 < 0) m_ld2 = int'(Column);
      end
      if (int'(Column) >= 60 && int'(Column) <= 67) m_da0[int'(Column) - 60] = DA0;
      if (int'(Column) == 1) m_pe1 = PixelEn;
      step();
    end
  endtask

  initial begin
    int n;
    Reset = 1'b1; FrameFormat = 1'b1; AnG = 1'b0; GMode = 3'd0;
    step(); step();

    // Reset state
    check("rst_hsn", HSn, 1);
    check("rst_fsn", FSn, 1);
    check("rst_bp", BackPorch, 1);
    check("rst_active", Active, 0);
    check("rst_pixen", PixelEn, 0);
    check("rst_fs", FrameStart, 0);
    check("rst_column", Column, 0);
    check("rst_line", Line, 0);

    // First negedge after release shows Column 0, Line 0
    Reset = 1'b0;
    step();
    check("rel_fs", FrameStart, 1);
    check("rel_column", Column, 0);
    check("rel_line", Line, 0);
    check("rel_hsn", HSn, 0);

    // Line 0: sync region, no picture
    measure_line();
    check("l0_hs_low", m_hs, 14);
    check("l0_active", m_act, 0);
    check("l0_bp", m_bp, 228);
    check("l0_load", m_ld, 0);
    check("l0_pixen", m_pe, 228);
    check("l0_fs_count", m_fs, 1);
    check("l0_da0", m_da0, 8'h00);

    wait_pos(0, 3);   check("fsn_l3", FSn, 0);
    wait_pos(0, 4);   check("fsn_l4", FSn, 1);
    wait_pos(100, 9); check("act_l9", Active, 0);

    // First PAL active line
    wait_pos(0, TOP_PAL);
    check("arow_top", AlphaRow, 0);
    measure_line();
    check("l10_hs_low", m_hs, 14);
    check("l10_active", m_act, 128);
    check("l10_first_act", m_first_act, 64);
    check("l10_last_act", m_last_act, 191);
    check("l10_bp", m_bp, 100);
    check("l10_load", m_ld, 32);
    check("l10_load1", m_ld1, 64);
    check("l10_load2", m_ld2, 68);
    check("l10_da0", m_da0, 8'h30);
    check("arow_l11", AlphaRow, 1);

    wait_pos(0, 21);   check("arow_l21", AlphaRow, 11);
    wait_pos(0, 22);   check("arow_l22", AlphaRow, 0);
    wait_pos(100, 33); check("act_l33", Active, 1);
    check("arow_l33", AlphaRow, 11);
    wait_pos(100, 34); check("act_l34", Active, 0);
    check("arow_l34", AlphaRow, 11);

    // Frame lengths: switch to NTSC mid-frame, the current frame keeps its PAL length
    frame_len(n, -1);
    frame_len(n, 15);
    check("pal_frame_len", n, 228 * VT_PAL);
    step();
    check("fs_width", FrameStart, 0);
    frame_len(n, -1);
    check("ntsc_frame_len", n + 1, 228 * VT_NTSC);

    // NTSC window
    wait_pos(100, 7);      check("ntsc_act_l7", Active, 0);
    wait_pos(0, TOP_NT);   check("ntsc_arow_top", AlphaRow, 0);
    AnG = 1'b1; GMode = 3'd0;
    wait_pos(100, TOP_NT); check("ntsc_act_l8", Active, 1);

    // Half-rate pixels from the next line on
    wait_pos(0, 9);
    measure_line();
    check("slow_pixen", m_pe, 114);
    check("slow_pixen_c1", m_pe1, 0);
    check("slow_load", m_ld, 16);
    check("slow_load1", m_ld1, 64);
    check("slow_load2", m_ld2, 72);
    check("slow_active", m_act, 128);

    GMode = 3'd3;
    wait_pos(0, 11);
    measure_line();
    check("gmode3_pixen", m_pe, 228);
    check("gmode3_load", m_ld, 32);

    // Mid-line reset
    wait_pos(150, 12);
    Reset = 1'b1;
    #1;
    check("mrst_hsn", HSn, 1);
    check("mrst_active", Active, 0);
    check("mrst_column", Column, 0);
    check("mrst_line", Line, 0);
    check("mrst_bp", BackPorch, 1);
    step(); step(); step();
    check("mrst_hold_column", Column, 0);
    Reset = 1'b0;
    step();
    check("mrel_column", Column, 0);
    check("mrel_line", Line, 0);
    check("mrel_fs", FrameStart, 1);
    step();
    check("mrel_column1", Column, 1);

    // Format register resets to PAL even though FrameFormat is still 0
    frame_len(n, -1);
    check("post_rst_frame_len", n + 1, 228 * VT_PAL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
